// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : trap_ctrl_pkg
// Brief  : Shared control encodings: next-PC opcodes, trap causes, trap FSM.
// Rev    : 1.0  initial release
// ============================================================================
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_TRAP   = 2'd2,
        NPC_MRET   = 2'd3
    } npc_op_e;

    localparam logic [31:0] CAUSE_EXT_IRQ = 32'd1;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd8;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    // Wraps modulo 2^32 by construction of the 32-bit add.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : trap_ctrl_if
// Brief  : EX-stage trap request and next-PC strobe bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
    logic        valid_EX;
    logic [31:0] PC_EX;
    logic        ecall_EX;
    logic        illegal_EX;
    logic        mret_EX;
    logic        PCWrite;
    logic        INT;
    logic        MRET;
    logic [31:0] SEPC;
    logic [31:0] SCAUSE;
    logic        flush;
    logic        in_trap;
    logic        double_fault;

    modport master (
        output valid_EX, PC_EX, ecall_EX, illegal_EX, mret_EX, PCWrite,
        input  INT, MRET, SEPC, SCAUSE, flush, in_trap, double_fault
    );

    modport slave (
        input  valid_EX, PC_EX, ecall_EX, illegal_EX, mret_EX, PCWrite,
        output INT, MRET, SEPC, SCAUSE, flush, in_trap, double_fault
    );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module : irq_sync
// Brief  : Multi-flop synchronizer plus rising-edge detector for ext_irq.
// Rev    : 1.0  initial release
// ============================================================================
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic async_in,
    output logic      rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module : trap_ctrl
// Brief  : Two-state trap controller: ecall/illegal/external-irq entry, mret.
// Rev    : 1.0  initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    input  wire logic   ext_irq,
    trap_ctrl_if.slave  bus
);
    logic [0:0]  r_state;
    logic [31:0] r_sepc;
    logic [31:0] r_scause;
    logic        r_pending;
    logic        r_dbl;

    logic        w_rise;
    logic        w_adv;
    logic        w_run;
    logic        w_take_ill;
    logic        w_take_ecall;
    logic        w_take_int;
    logic        w_take;
    logic        w_ret;
    logic [31:0] w_new_sepc;
    logic [31:0] w_new_cause;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (ext_irq),
        .rise     (w_rise)
    );

    // rstn gates the strobes so reset silences them without waiting for a clock.
    assign w_adv        = rstn & bus.PCWrite & bus.valid_EX;
    assign w_run        = (r_state == ST_RUN);
    assign w_take_ill   = w_adv & w_run & bus.illegal_EX;
    assign w_take_ecall = w_adv & w_run & ~bus.illegal_EX & bus.ecall_EX;
    assign w_take_int   = w_adv & w_run & ~bus.illegal_EX & ~bus.ecall_EX & r_pending;
    assign w_take       = w_take_ill | w_take_ecall | w_take_int;
    assign w_ret        = w_adv & ~w_run & bus.mret_EX;

    always_comb begin
        w_new_sepc  = pc_plus4(bus.PC_EX);
        w_new_cause = CAUSE_ECALL;
        if (w_take_ill) begin
            w_new_cause = CAUSE_ILLEGAL;
        end else if (w_take_int) begin
            w_new_cause = CAUSE_EXT_IRQ;
            w_new_sepc  = bus.PC_EX;
        end
    end

    assign bus.INT          = w_take_int;
    assign bus.MRET         = w_ret;
    assign bus.flush        = w_take | w_ret;
    assign bus.SEPC         = w_take ? w_new_sepc  : r_sepc;
    assign bus.SCAUSE       = w_take ? w_new_cause : r_scause;
    assign bus.in_trap      = (r_state == ST_HANDLER);
    assign bus.double_fault = r_dbl;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_RUN;
            r_sepc    <= '0;
            r_scause  <= '0;
            r_pending <= 1'b0;
            r_dbl     <= 1'b0;
        end else begin
            if (w_take) begin
                r_state  <= ST_HANDLER;
                r_sepc   <= w_new_sepc;
                r_scause <= w_new_cause;
            end else if (w_ret) begin
                r_state  <= ST_RUN;
            end
            // An edge arriving in the same cycle as the take survives the clear.
            r_pending <= (r_pending & ~w_take_int) | w_rise;
            r_dbl     <= r_dbl | (w_adv & ~w_run & (bus.ecall_EX | bus.illegal_EX));
        end
    end
endmodule
`default_nettype wire
